pwm_multi_gen: RTL and testbench
================================

# pwm_multi_gen

Multi-channel PWM generator with per-channel period and ON-time counters held inside the block. Successor to the single-channel PWM state machine: the external counter datapath is absorbed, there are NUM_CH independent channels, periods are back-to-back with no idle gap, and duty changes are glitch-free at frame boundaries. It sits between the register bank (which supplies period/ON values and enables) and the motor/servo output pins.

## Interface
- NUM_CH, 4, number of independent PWM channels (1..16)
- CNT_W, 16, width of period and ON-time values in clock cycles
- PWM_UNIT, 0, unit identifier; no functional effect
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low; one clock; reset is synchronous and active-low
- pwm_enable  in  NUM_CH  per-channel run enable; level sensitive
- T_period  in  NUM_CH*CNT_W  per-channel period in cycles; channel n at [n*CNT_W +: CNT_W]
- T_on  in  NUM_CH*CNT_W  per-channel ON time in cycles; same packing
- pwm  out  NUM_CH  registered PWM outputs
- period_done  out  NUM_CH  one-cycle pulse in the last cycle of each completed frame
- active  out  NUM_CH  channel is in S_RUN

## Operation
- Per-channel FSM, two states: S_IDLE, S_RUN. Per channel: cnt[CNT_W], active period P[CNT_W], active ON time H[CNT_W].
- S_IDLE: pwm=0, cnt=0. If pwm_enable[n]=1 and T_period[n]!=0: latch P<=T_period, H<=T_on, cnt<=0 -> S_RUN.
- S_RUN: pwm[n] registered = (cnt < H). cnt increments each cycle.
- Frame end (cnt==P-1): period_done pulses; cnt<=0; P,H reloaded from current T_period/T_on in the same cycle, so the next frame starts immediately with the new values (no gap cycle). If the new T_period==0 -> S_IDLE instead.
- Mid-frame changes to T_period/T_on are ignored until frame end (shadowing).
- pwm_enable[n]=0 in S_RUN: -> S_IDLE next edge; pwm drops to 0 next edge; no period_done for the truncated frame.
- Duty clamping: H=0 -> pwm stays 0 for the whole frame; H>=P -> pwm stays 1 for the whole frame (100%); no glitch at the wrap.
- Arithmetic: compare unsigned, CNT_W bits; cnt never exceeds P-1 so no overflow; P=2^CNT_W-1 is the maximum period.
- Channels are fully independent; no shared state except reset (and sync_start, see Configuration).

## Timing
- Reset values: pwm=0, period_done=0, active=0, all cnt/P/H=0, every FSM in S_IDLE.
- reset low mid-frame: outputs 0 on the next edge regardless of enable; after release, channel restarts a full frame one cycle after enable is seen high.
- Latency: pwm_enable sampled high at edge k -> S_RUN and active=1 after edge k; pwm high from edge k+1 (if H>0) for exactly min(H,P) cycles of each P-cycle frame.
- period_done asserted for one cycle, coincident with the final cycle of the frame (cnt==P-1).
- P=1: every cycle is a frame end; pwm=1 continuously if H>=1, else 0; period_done high continuously.

## Configuration
- PWM_SYNC_EN defined: adds input sync_start (1 bit). When sync_start=1, every channel in S_RUN sets cnt<=0 and reloads P,H next edge (new frame, no period_done for the truncated one); channels in S_IDLE with enable high enter S_RUN in the same edge. sync_start has priority over frame-end wrap; pwm_enable=0 has priority over sync_start.
- PWM_SYNC_EN undefined: no sync_start port; channels free-run from their own enable edges.

## Test plan
- Reset/idle: reset=0 3 cycles with enables high -> pwm, period_done, active all 0; release with enable=0 -> remain 0.
- Basic duty: ch0 T_period=10, T_on=3, enable at edge k -> pwm[0] high edges k+1..k+3, low k+4..k+10, repeating with period 10; period_done each 10th cycle.
- Shadowing: change ch1 T_on 4->7 mid-frame (T_period=12) -> current frame keeps 4 high cycles, next frame has 7, no gap between frames.
- Boundaries: T_on=0 -> pwm constant 0; T_on=20, T_period=8 -> pwm constant 1; T_period=0 with enable -> stays S_IDLE, active=0.
- Disable/reset mid-frame: drop enable at cnt=5 of 10 -> pwm 0 next edge, no period_done; assert reset mid-frame on another channel -> all outputs 0 next edge.
- With PWM_SYNC_EN: ch0 P=10, ch1 P=7, pulse sync_start -> both cnt restart at 0, rising pwm edges aligned on the following cycle.

Source files
------------

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: one IDLE/RUN state machine per channel, each with shadowed period and ON time.
// Defining PWM_SYNC_EN adds a sync_start input that restarts the frame on every running channel.
module pwm_multi_gen #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int PWM_UNIT = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       pwm_enable,
  input  logic [NUM_CH*CNT_W-1:0] T_period,
  input  logic [NUM_CH*CNT_W-1:0] T_on,
`ifdef PWM_SYNC_EN
  input  logic                    sync_start,
`endif
  output logic [NUM_CH-1:0]       pwm,
  output logic [NUM_CH-1:0]       period_done,
  output logic [NUM_CH-1:0]       active
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  logic sync_w;
`ifdef PWM_SYNC_EN
  assign sync_w = sync_start;
`else
  assign sync_w = 1'b0;
`endif

  if (NUM_CH < 1 || NUM_CH > 16 || PWM_UNIT < 0) begin : g_bad_cfg
    $error("pwm_multi_gen: unsupported parameter values");
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] p_q, p_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic             pwm_q, pwm_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] tp, ton;
    logic             frame_end;

    assign tp        = T_period[n*CNT_W +: CNT_W];
    assign ton       = T_on[n*CNT_W +: CNT_W];
    assign frame_end = (cnt_q == p_q - CNT_W'(1));

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      h_d     = h_q;
      pwm_d   = 1'b0;
      done_d  = 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (pwm_enable[n] && tp != '0) begin
            state_d = S_RUN;
            p_d     = tp;
            h_d     = ton;
          end
        end
        default: begin
          if (!pwm_enable[n]) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            // H >= P naturally yields 100% duty since cnt never exceeds P-1
            pwm_d = (cnt_q < h_q);
            if (sync_w || frame_end) begin
              done_d = !sync_w;
              cnt_d  = '0;
              p_d    = tp;
              h_d    = ton;
              if (tp == '0) state_d = S_IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        p_q     <= '0;
        h_q     <= '0;
        pwm_q   <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        p_q     <= p_d;
        h_q     <= h_d;
        pwm_q   <= pwm_d;
        done_q  <= done_d;
      end
    end

    assign pwm[n]         = pwm_q;
    assign period_done[n] = done_q;
    assign active[n]      = (state_q == S_RUN);
  end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Bench for pwm_multi_gen: frame-arithmetic reference model checked every cycle, plus directed literal checks.
module tb_pwm_multi_gen;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_CH-1:0]       pwm_enable;
  logic [NUM_CH*CNT_W-1:0] T_period, T_on;
  logic [NUM_CH-1:0]       pwm, period_done, active;
  logic                    sync_v;
`ifdef PWM_SYNC_EN
  logic                    sync_start;
  assign sync_v = sync_start;
`else
  assign sync_v = 1'b0;
`endif

  pwm_multi_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PWM_UNIT(0)) dut (
    .clk(clk),
    .reset(reset),
    .pwm_enable(pwm_enable),
    .T_period(T_period),
    .T_on(T_on),
`ifdef PWM_SYNC_EN
    .sync_start(sync_start),
`endif
    .pwm(pwm),
    .period_done(period_done),
    .active(active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a running channel remembers the edge its frame began on; output at
  // edge t is position i = t - start - 1 within the frame.
  longint t = 0;
  bit     m_run [NUM_CH];
  longint m_f0  [NUM_CH];
  longint m_p   [NUM_CH];
  longint m_h   [NUM_CH];
  logic [NUM_CH-1:0] exp_pwm, exp_done, exp_act;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int n = 0; n < NUM_CH; n++) begin
      longint tp, ton, i;
      tp  = longint'(T_period[n*CNT_W +: CNT_W]);
      ton = longint'(T_on[n*CNT_W +: CNT_W]);
      exp_pwm[n]  = 1'b0;
      exp_done[n] = 1'b0;
      if (!reset) begin
        m_run[n] = 0;
      end else if (!m_run[n]) begin
        if (pwm_enable[n] && tp != 0) begin
          m_run[n] = 1; m_f0[n] = t; m_p[n] = tp; m_h[n] = ton;
        end
      end else if (!pwm_enable[n]) begin
        m_run[n] = 0;
      end else begin
        i = t - m_f0[n] - 1;
        exp_pwm[n]  = (i < m_h[n]);
        exp_done[n] = (i == m_p[n] - 1) && !sync_v;
        if (sync_v || i == m_p[n] - 1) begin
          if (tp != 0) begin
            m_f0[n] = t; m_p[n] = tp; m_h[n] = ton;
          end else begin
            m_run[n] = 0;
          end
        end
      end
      exp_act[n] = m_run[n];
    end
    t++;
    #1;
    checks++;
    if (pwm !== exp_pwm || period_done !== exp_done || active !== exp_act) begin
      errors++;
      $display("FAIL model cycle %0d: pwm/done/active got %b/%b/%b expected %b/%b/%b",
               t, pwm, period_done, active, exp_pwm, exp_done, exp_act);
    end
  endtask

  task automatic set_ch(input int n, input int p, input int h);
    T_period[n*CNT_W +: CNT_W] = CNT_W'(p);
    T_on[n*CNT_W +: CNT_W]     = CNT_W'(h);
  endtask

  logic [19:0] cap_p, cap_d, lit_p, lit_d;
  logic [23:0] cap_s, lit_s;
  int hi2, hi3;

  initial begin
    for (int n = 0; n < NUM_CH; n++) begin
      m_run[n] = 0; m_f0[n] = 0; m_p[n] = 0; m_h[n] = 0;
    end
    reset      = 1'b0;
    pwm_enable = '1;
    T_period   = '0;
    T_on       = '0;
`ifdef PWM_SYNC_EN
    sync_start = 1'b0;
`endif
    for (int n = 0; n < NUM_CH; n++) set_ch(n, 10, 3);

    // reset held with enables high
    repeat (3) begin
      tick();
      chk("reset_outputs", {pwm, period_done, active}, '0);
    end
    reset = 1'b1;
    pwm_enable = '0;
    repeat (2) begin
      tick();
      chk("idle_after_reset", {pwm, period_done, active}, '0);
    end

    // basic duty: P=10, H=3
    set_ch(0, 10, 3);
    pwm_enable[0] = 1'b1;
    tick();
    chk("start_active", active[0], 1);
    chk("start_pwm", pwm[0], 0);
    for (int j = 0; j < 20; j++) begin
      tick();
      cap_p[j] = pwm[0];
      cap_d[j] = period_done[0];
    end
    lit_p = 20'b00000001110000000111;
    lit_d = 20'b10000000001000000000;
    chk("duty_pwm", cap_p, lit_p);
    chk("duty_done", cap_d, lit_d);

    // shadowing: ON time 4 -> 7 mid-frame
    set_ch(1, 12, 4);
    pwm_enable[1] = 1'b1;
    tick();
    for (int j = 0; j < 24; j++) begin
      tick();
      cap_s[j] = pwm[1];
      if (j == 2) T_on[1*CNT_W +: CNT_W] = CNT_W'(7);
    end
    lit_s = 24'b000001111111000000001111;
    chk("shadow_pwm", cap_s, lit_s);

    // boundaries: H=0 and H>P
    set_ch(2, 5, 0);
    set_ch(3, 8, 20);
    pwm_enable[3:2] = 2'b11;
    tick();
    hi2 = 0; hi3 = 0;
    for (int j = 0; j < 16; j++) begin
      tick();
      hi2 += int'(pwm[2]);
      hi3 += int'(pwm[3]);
    end
    chk("h_zero_highs", hi2, 0);
    chk("h_full_highs", hi3, 16);
    pwm_enable[2] = 1'b0;
    set_ch(2, 0, 3);
    tick();
    pwm_enable[2] = 1'b1;
    tick();
    tick();
    chk("p_zero_active", active[2], 0);

    // disable mid-frame at cnt=5
    pwm_enable[0] = 1'b0;
    tick();
    set_ch(0, 10, 7);
    pwm_enable[0] = 1'b1;
    tick();
    repeat (5) tick();
    chk("pre_disable_pwm", pwm[0], 1);
    pwm_enable[0] = 1'b0;
    tick();
    chk("disable_pwm", pwm[0], 0);
    chk("disable_done", period_done[0], 0);
    chk("disable_active", active[0], 0);

    // reset mid-frame
    reset = 1'b0;
    tick();
    chk("reset_midframe", {pwm, period_done, active}, '0);
    reset = 1'b1;
    tick();

`ifdef PWM_SYNC_EN
    set_ch(0, 10, 3);
    set_ch(1, 7, 3);
    pwm_enable[1:0] = 2'b11;
    repeat (5) tick();
    sync_start = 1'b1;
    tick();
    sync_start = 1'b0;
    tick();
    chk("sync_aligned_high", pwm[1:0], 2'b11);
    repeat (3) tick();
    chk("sync_aligned_low", pwm[1:0], 2'b00);
`endif

    // randomized phase
    for (int c = 0; c < 4000; c++) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if ($urandom_range(0, 99) < 3) pwm_enable[n] = ~pwm_enable[n];
        if ($urandom_range(0, 99) < 10)
          set_ch(n, int'($urandom_range(0, 12)), int'($urandom_range(0, 14)));
      end
      reset = ($urandom_range(0, 199) != 0);
`ifdef PWM_SYNC_EN
      sync_start = ($urandom_range(0, 49) == 0);
`endif
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
